// File: rtl/pipeline_ctrl_if.sv
// Hazard/redirect bundle between pipeline stages and the pipeline controller.
// Build option PIPELINE_CTRL_PERF_CNT_EN adds the stall-cycle counter output.
interface pipeline_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        ex_br_i;
  logic [31:0] ex_br_addr_i;
  logic        trap_i;
  logic [5:0]  stall_o;
  logic        br_o;
  logic [31:0] br_addr_o;
  logic        flush_o;
  logic        busy_o;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  // Controller side.
  modport master (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  ex_br_i, ex_br_addr_i, trap_i,
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    output stall_cnt_o,
`endif
    output stall_o, br_o, br_addr_o, flush_o, busy_o
  );

  // Pipeline-stage side.
  modport slave (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output ex_br_i, ex_br_addr_i, trap_i,
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    input  stall_cnt_o,
`endif
    input  stall_o, br_o, br_addr_o, flush_o, busy_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/redirect/trap-flush controller; stall and branch outputs are combinational (0 cycles).
// No backpressure: stalled branches are parked in a one-entry pending register. Option: PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.master ctrl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_pend_vld;
  logic [31:0] r_pend_addr;

  state_t      w_state_nxt;
  logic        w_pend_vld_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic [5:0]  w_stall_idle;
  logic [5:0]  w_stall;
  logic        w_br;
  logic [31:0] w_br_addr;
  logic        w_flush;
  logic        w_busy;

  // Deepest requesting stage wins; it freezes itself and everything upstream.
  always_comb begin
    if (ctrl.stallreq_mem_i)     w_stall_idle = 6'b011111;
    else if (ctrl.stallreq_ex_i) w_stall_idle = 6'b001111;
    else if (ctrl.stallreq_id_i) w_stall_idle = 6'b000111;
    else if (ctrl.stallreq_if_i) w_stall_idle = 6'b000011;
    else                         w_stall_idle = 6'b000000;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_stall         = 6'b000000;
    w_br            = 1'b0;
    w_br_addr       = 32'h0000_0000;
    w_flush         = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_stall_idle;
        if (ctrl.trap_i) begin
          w_state_nxt    = ctrl.stallreq_mem_i ? DRAIN : FLUSH;
          w_pend_vld_nxt = 1'b0;
        end else begin
          w_br = (ctrl.ex_br_i | r_pend_vld) & ~w_stall_idle[0];
          if (w_br) begin
            w_br_addr      = ctrl.ex_br_i ? ctrl.ex_br_addr_i : r_pend_addr;
            w_pend_vld_nxt = 1'b0;
          end else if (ctrl.ex_br_i) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = ctrl.ex_br_addr_i;
          end
        end
      end
      DRAIN: begin
        // MEM keeps running so its outstanding access can complete before the flush.
        w_stall        = 6'b001111;
        w_busy         = 1'b1;
        w_pend_vld_nxt = 1'b0;
        if (!ctrl.stallreq_mem_i) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_flush        = 1'b1;
        w_br           = 1'b1;
        w_br_addr      = TRAP_VEC;
        w_busy         = 1'b1;
        w_pend_vld_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_pend_vld_nxt = 1'b0;
      end
    endcase
    // Outputs are quiet throughout the reset cycle, whatever state is being left.
    if (rst) begin
      w_stall   = 6'b000000;
      w_br      = 1'b0;
      w_br_addr = 32'h0000_0000;
      w_flush   = 1'b0;
      w_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  assign ctrl.stall_o   = w_stall;
  assign ctrl.br_o      = w_br;
  assign ctrl.br_addr_o = w_br_addr;
  assign ctrl.flush_o   = w_flush;
  assign ctrl.busy_o    = w_busy;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)            r_stall_cnt <= 32'h0000_0000;
    else if (|w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign ctrl.stall_cnt_o = r_stall_cnt;
`endif

endmodule
